// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package riscv_pkg;

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_TRAP
  } fetch_state_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam int          PC_STEP   = 4;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Next-PC selection: sequential pc+4 or redirect target, with alignment handling.
// Behaviour depends on FETCH_MISALIGN_TRAP_EN (flag misaligned targets vs. force word alignment).
module pc_next
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misaligned
);

  always_comb begin
    pc_plus4 = pc + XLEN'(PC_STEP);
`ifdef FETCH_MISALIGN_TRAP_EN
    misaligned = pc_src && (pc_target[1:0] != 2'b00);
    next_pc    = pc_src ? pc_target : pc_plus4;
`else
    // Low address bits are dropped so a redirect always lands on a word boundary.
    misaligned = 1'b0;
    next_pc    = pc_src ? (pc_target & ~XLEN'(3)) : pc_plus4;
`endif
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, handshakes with imem and holds the fetched word.
// Optional FETCH_MISALIGN_TRAP_EN traps on misaligned redirects instead of aligning them.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target,
  input  logic            exec_done,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misalign_trap
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] next_pc;
  logic [31:0]     instr_q;
  logic            instr_valid_q;
  logic            misaligned;
  logic            req_valid;

  pc_next #(.XLEN(XLEN)) u_pc_next (
    .pc         (pc_q),
    .pc_src     (pc_src),
    .pc_target  (pc_target),
    .next_pc    (next_pc),
    .pc_plus4   (pc_plus4),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      instr_q       <= INSTR_NOP;
      instr_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_WAIT: begin
          if (imem_rsp_valid) begin
            instr_q       <= imem_rsp_data;
            instr_valid_q <= 1'b1;
          end
        end
        S_HOLD: begin
          // A trapping redirect leaves the PC pointing at the offending branch.
          if (exec_done) begin
            instr_valid_q <= 1'b0;
            if (!misaligned) begin
              pc_q <= next_pc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    req_valid = 1'b0;
    case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        req_valid = 1'b1;
        if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (exec_done) begin
          state_d = misaligned ? S_TRAP : S_REQ;
        end
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_BOOT;
    endcase
  end

  assign imem_req_valid = req_valid;
  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = instr_valid_q;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign_trap = (state_q == S_TRAP);
`else
  assign misalign_trap = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed steps with a scoreboard of expected fetches.
module tb_fetch_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        exec_done;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign_trap;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] expected_pc;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_src         (pc_src),
    .pc_target      (pc_target),
    .exec_done      (exec_done),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .misalign_trap  (misalign_trap)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[19:0], 12'h093} ^ 32'h0A50_0000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic waitReq(input int budget, output int cycles);
    cycles = 0;
    while (imem_req_valid !== 1'b1 && cycles < budget) begin
      step();
      cycles++;
    end
    checkOutput("req_valid_wait", {31'b0, imem_req_valid}, 32'd1);
  endtask

  // One fetch: optional backpressure, acceptance, delayed response, then hold checks.
  task automatic applyStimulus(input int ready_wait, input int rsp_wait);
    logic [31:0] held;
    exp_t        e;
    checkOutput("req_addr", imem_addr, expected_pc);
    held = imem_addr;
    imem_req_ready = 1'b0;
    for (int i = 0; i < ready_wait; i++) begin
      step();
      checkOutput("bp_req_valid", {31'b0, imem_req_valid}, 32'd1);
      checkOutput("bp_addr", imem_addr, held);
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    sb.push_back('{pc: expected_pc, instr: memWord(expected_pc)});
    checkOutput("req_dropped", {31'b0, imem_req_valid}, 32'd0);
    exec_done = 1'b1;
    pc_src    = 1'b1;
    pc_target = 32'h0000_0800;
    for (int i = 0; i < rsp_wait; i++) begin
      step();
      checkOutput("early_valid", {31'b0, instr_valid}, 32'd0);
    end
    exec_done      = 1'b0;
    pc_src         = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = memWord(expected_pc);
    step();
    imem_rsp_valid = 1'b0;
    checkOutput("instr_valid", {31'b0, instr_valid}, 32'd1);
    checkOutput("sb_size", sb.size(), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("instr", instr, e.instr);
      checkOutput("pc", pc, e.pc);
      checkOutput("pc_plus4", pc_plus4, e.pc + 32'd4);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      step();
      imem_rsp_valid = 1'b0;
      checkOutput("hold_instr", instr, e.instr);
      checkOutput("hold_valid", {31'b0, instr_valid}, 32'd1);
    end
  endtask

  task automatic retire(input logic src, input logic [31:0] target);
    exec_done = 1'b1;
    pc_src    = src;
    pc_target = target;
    step();
    exec_done = 1'b0;
    pc_src    = 1'b0;
    expected_pc = src ? (target & 32'hFFFF_FFFC) : expected_pc + 32'd4;
    checkOutput("retire_valid_drop", {31'b0, instr_valid}, 32'd0);
  endtask

  initial begin
    int cyc;
    reset          = 1'b1;
    pc_src         = 1'b0;
    pc_target      = '0;
    exec_done      = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    expected_pc    = 32'h0000_0000;
    step();
    step();
    step();
    checkOutput("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    checkOutput("rst_pc", pc, 32'h0000_0000);
    checkOutput("rst_instr", instr, INSTR_NOP);
    checkOutput("rst_trap", {31'b0, misalign_trap}, 32'd0);
    checkOutput("rst_pc_plus4", pc_plus4, 32'd4);

    $display("[TB] boot and first fetch");
    reset = 1'b0;
    waitReq(8, cyc);
    checkOutput("boot_cycles", cyc, 32'd1);
    applyStimulus(0, 0);

    $display("[TB] straight-line and taken branch");
    retire(1'b0, 32'h0);
    waitReq(8, cyc);
    applyStimulus(0, 0);
    retire(1'b0, 32'h0);
    waitReq(8, cyc);
    applyStimulus(0, 0);
    retire(1'b1, 32'h0000_0040);
    waitReq(8, cyc);
    checkOutput("branch_addr", imem_addr, 32'h0000_0040);

    $display("[TB] backpressure and slow response");
    applyStimulus(5, 4);

    $display("[TB] reset during wait");
    retire(1'b0, 32'h0);
    waitReq(8, cyc);
    checkOutput("pre_rst_addr", imem_addr, 32'h0000_0044);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    reset          = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hCAFE_F00D;
    step();
    imem_rsp_valid = 1'b0;
    reset          = 1'b0;
    checkOutput("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("mid_rst_pc", pc, 32'h0000_0000);
    checkOutput("mid_rst_instr", instr, INSTR_NOP);
    checkOutput("mid_rst_req", {31'b0, imem_req_valid}, 32'd0);
    expected_pc = 32'h0000_0000;
    waitReq(8, cyc);
    applyStimulus(0, 0);
    retire(1'b0, 32'h0);
    waitReq(8, cyc);
    applyStimulus(0, 1);
    retire(1'b0, 32'h0);
    waitReq(8, cyc);
    applyStimulus(2, 0);
    retire(1'b0, 32'h0);
    waitReq(8, cyc);
    checkOutput("seq_addr_c", imem_addr, 32'h0000_000C);
    applyStimulus(1, 2);

    $display("[TB] wrap and misaligned redirect");
    retire(1'b1, 32'hFFFF_FFFC);
    waitReq(8, cyc);
    applyStimulus(0, 0);
    retire(1'b0, 32'h0);
    waitReq(8, cyc);
    checkOutput("wrap_addr", imem_addr, 32'h0000_0000);
    applyStimulus(0, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    exec_done = 1'b1;
    pc_src    = 1'b1;
    pc_target = 32'h0000_0042;
    step();
    exec_done = 1'b0;
    pc_src    = 1'b0;
    checkOutput("trap_flag", {31'b0, misalign_trap}, 32'd1);
    checkOutput("trap_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("trap_pc", pc, 32'h0000_0000);
    for (int i = 0; i < 4; i++) begin
      imem_req_ready = 1'b1;
      step();
      checkOutput("trap_no_req", {31'b0, imem_req_valid}, 32'd0);
      checkOutput("trap_hold", {31'b0, misalign_trap}, 32'd1);
    end
    imem_req_ready = 1'b0;
`else
    retire(1'b1, 32'h0000_0042);
    waitReq(8, cyc);
    checkOutput("align_addr", imem_addr, 32'h0000_0040);
    checkOutput("no_trap", {31'b0, misalign_trap}, 32'd0);
    applyStimulus(0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
